// File: rtl/seq_divider_pkg.sv
// Shared types and limits for the sequential restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

    localparam int DIV_MAX_WIDTH = 32;

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider; master is the requester, slave is the divider.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring division step: shift in the next dividend bit, subtract the divisor when it fits.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             n_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);
    logic [WIDTH:0] shifted;

    // Compare is WIDTH+1 bits wide; the surviving remainder is always < divisor, so WIDTH bits hold it.
    always_comb begin
        shifted = {rem_in, n_bit};
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating quotient, remainder follows dividend).
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          reset,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    div_state_t       state, next_state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] n_sh;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;

    logic             in_ready;
    logic             out_valid;
    logic             accept;

    logic [WIDTH-1:0] n_mag;
    logic [WIDTH-1:0] d_mag;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] q_raw;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic             n_neg;
    logic             d_neg;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .n_bit   (n_sh[WIDTH-1]),
        .divisor (d_reg),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = ~reset;
                if (bus.in_valid && !reset) begin
                    next_state = (bus.divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (count == '0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign accept = bus.in_valid & in_ready;

    // The dividend register doubles as the quotient register: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    assign q_raw = {n_sh[WIDTH-2:0], q_bit};

    always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
        n_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
        d_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
        q_res = (n_neg ^ d_neg) ? -q_raw : q_raw;
        r_res = n_neg ? -rem_next : rem_next;
`else
        n_mag = bus.dividend;
        d_mag = bus.divisor;
        q_res = q_raw;
        r_res = rem_next;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            n_sh        <= '0;
            d_reg       <= '0;
            rem         <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            n_neg       <= 1'b0;
            d_neg       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        n_sh  <= n_mag;
                        d_reg <= d_mag;
                        rem   <= '0;
                        count <= CW'(WIDTH - 1);
`ifdef SEQ_DIVIDER_SIGNED_EN
                        n_neg <= bus.dividend[WIDTH-1];
                        d_neg <= bus.divisor[WIDTH-1];
`endif
                        if (bus.divisor == '0) begin
                            quotient_r  <= '1;
                            remainder_r <= bus.dividend;
                            dbz_r       <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    n_sh  <= q_raw;
                    rem   <= rem_next;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        quotient_r  <= q_res;
                        remainder_r <= r_res;
                        dbz_r       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;
endmodule
